johnson_counter_n: RTL and testbench

// Parametrised Johnson (twisted-ring) / ring counter: successor to the fixed 4-bit Johnson block.

---
 rtl/johnson_counter_n.sv | 120 ++++++++++++
 tb/tb_johnson_counter_n.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/johnson_counter_n.sv
// Parametrised Johnson / one-hot ring counter with load, direction, phase index,
// wrap pulse and self-correction of illegal states back to the reset value.
module johnson_counter_n #(
   parameter int WIDTH     = 4,
   parameter bit RING_MODE = 1'b0,
   localparam int PW       = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [PW-1:0]    phase,
   output logic             wrap,
   output logic             illegal
);

   localparam logic [WIDTH-1:0] RST_VAL   = RING_MODE ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
   localparam logic [PW-1:0]    PHASE_MAX = PW'(RING_MODE ? WIDTH-1 : 2*WIDTH-1);

   logic [WIDTH-1:0] q_q, q_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic             wrap_q, wrap_d;
   logic             illegal_q, illegal_d;
   logic [WIDTH-1:0] fwd_val, rev_val;
   logic [PW-1:0]    cur_phase;

   // Johnson legal states have at most one 0/1 boundary between adjacent bits.
   function automatic logic is_legal(input logic [WIDTH-1:0] v);
      int cnt = 0;
      if (RING_MODE) begin
         for (int i = 0; i < WIDTH; i++)
            if (v[i]) cnt++;
         return (cnt == 1);
      end else begin
         for (int i = 0; i < WIDTH-1; i++)
            if (v[i] != v[i+1]) cnt++;
         return (cnt <= 1);
      end
   endfunction

   function automatic logic [PW-1:0] phase_of(input logic [WIDTH-1:0] v);
      int k = 0;
      int p = 0;
      if (RING_MODE) begin
         for (int i = 0; i < WIDTH; i++)
            if (v[i]) p = WIDTH-1-i;
      end else begin
         for (int i = 0; i < WIDTH; i++)
            if (v[i]) k++;
         if (v[WIDTH-1])  p = k;
         else if (k == 0) p = 0;
         else             p = 2*WIDTH - k;
      end
      return PW'(p);
   endfunction

   always_comb begin
      cur_phase = phase_of(q_q);
      if (RING_MODE) begin
         fwd_val = {q_q[0], q_q[WIDTH-1:1]};
         rev_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      end else begin
         fwd_val = {~q_q[0], q_q[WIDTH-1:1]};
         rev_val = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      end

      q_d       = q_q;
      phase_d   = phase_q;
      wrap_d    = 1'b0;
      illegal_d = 1'b0;

      if (load) begin
         if (is_legal(load_val)) begin
            q_d     = load_val;
            phase_d = phase_of(load_val);
         end else begin
            q_d       = RST_VAL;
            phase_d   = '0;
            illegal_d = 1'b1;
         end
      end else if (!is_legal(q_q)) begin
         q_d       = RST_VAL;
         phase_d   = '0;
         illegal_d = 1'b1;
      end else if (en) begin
         if (dir) begin
            q_d     = fwd_val;
            phase_d = (cur_phase == PHASE_MAX) ? '0 : cur_phase + PW'(1);
            wrap_d  = (cur_phase == PHASE_MAX);
         end else begin
            q_d     = rev_val;
            phase_d = (cur_phase == '0) ? PHASE_MAX : cur_phase - PW'(1);
            wrap_d  = (cur_phase == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q_q       <= RST_VAL;
         phase_q   <= '0;
         wrap_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         phase_q   <= phase_d;
         wrap_q    <= wrap_d;
         illegal_q <= illegal_d;
      end
   end

   assign q       = q_q;
   assign phase   = phase_q;
   assign wrap    = wrap_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_johnson_counter_n.sv
// Directed bench for johnson_counter_n: W=4 Johnson, W=4 ring and W=6 Johnson instances.
module tb_johnson_counter_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic       a_rst = 1'b0, a_en = 1'b0, a_dir = 1'b1, a_load = 1'b0;
   logic [3:0] a_load_val = '0;
   logic [3:0] a_q;
   logic [2:0] a_phase;
   logic       a_wrap, a_ill;

   logic       b_rst = 1'b0, b_en = 1'b0, b_dir = 1'b1, b_load = 1'b0;
   logic [3:0] b_load_val = '0;
   logic [3:0] b_q;
   logic [2:0] b_phase;
   logic       b_wrap, b_ill;

   logic       c_rst = 1'b0, c_en = 1'b0, c_dir = 1'b1, c_load = 1'b0;
   logic [5:0] c_load_val = '0;
   logic [5:0] c_q;
   logic [3:0] c_phase;
   logic       c_wrap, c_ill;

   johnson_counter_n #(.WIDTH(4), .RING_MODE(1'b0)) u_j4 (
      .clk(clk), .rst(a_rst), .en(a_en), .dir(a_dir), .load(a_load), .load_val(a_load_val),
      .q(a_q), .phase(a_phase), .wrap(a_wrap), .illegal(a_ill));

   johnson_counter_n #(.WIDTH(4), .RING_MODE(1'b1)) u_r4 (
      .clk(clk), .rst(b_rst), .en(b_en), .dir(b_dir), .load(b_load), .load_val(b_load_val),
      .q(b_q), .phase(b_phase), .wrap(b_wrap), .illegal(b_ill));

   johnson_counter_n #(.WIDTH(6), .RING_MODE(1'b0)) u_j6 (
      .clk(clk), .rst(c_rst), .en(c_en), .dir(c_dir), .load(c_load), .load_val(c_load_val),
      .q(c_q), .phase(c_phase), .wrap(c_wrap), .illegal(c_ill));

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      tick();
      n_cmp++; if (a_q !== 4'b0000) begin n_err++; $display("FAIL rst_j4_q got %b exp %b", a_q, 4'b0000); end
      n_cmp++; if (a_phase !== 3'd0) begin n_err++; $display("FAIL rst_j4_phase got %0d exp 0", a_phase); end
      n_cmp++; if (a_wrap !== 1'b0 || a_ill !== 1'b0) begin n_err++; $display("FAIL rst_j4_pulses got %b%b exp 00", a_wrap, a_ill); end
      n_cmp++; if (b_q !== 4'b1000) begin n_err++; $display("FAIL rst_r4_q got %b exp %b", b_q, 4'b1000); end
      n_cmp++; if (c_q !== 6'b000000) begin n_err++; $display("FAIL rst_j6_q got %b exp %b", c_q, 6'b000000); end
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
   endtask

   task automatic test_johnson_fwd();
      logic [3:0] exp_q [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
      logic [2:0] exp_p [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      int wraps = 0;
      a_en = 1'b1; a_dir = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (a_wrap === 1'b1) wraps++;
         n_cmp++; if (a_q !== exp_q[i]) begin n_err++; $display("FAIL fwd_q[%0d] got %b exp %b", i, a_q, exp_q[i]); end
         n_cmp++; if (a_phase !== exp_p[i]) begin n_err++; $display("FAIL fwd_phase[%0d] got %0d exp %0d", i, a_phase, exp_p[i]); end
         n_cmp++; if (a_wrap !== (i == 7)) begin n_err++; $display("FAIL fwd_wrap[%0d] got %b exp %b", i, a_wrap, (i == 7)); end
      end
      n_cmp++; if (wraps != 1) begin n_err++; $display("FAIL fwd_wrap_count got %0d exp 1", wraps); end
   endtask

   task automatic test_johnson_rev();
      logic [3:0] exp_q [4] = '{4'b1100, 4'b1000, 4'b0000, 4'b0001};
      logic [2:0] exp_p [4] = '{3'd2, 3'd1, 3'd0, 3'd7};
      a_en = 1'b1; a_dir = 1'b1;
      repeat (3) tick();
      n_cmp++; if (a_q !== 4'b1110 || a_phase !== 3'd3) begin n_err++; $display("FAIL rev_start got %b/%0d exp 1110/3", a_q, a_phase); end
      a_dir = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (a_q !== exp_q[i]) begin n_err++; $display("FAIL rev_q[%0d] got %b exp %b", i, a_q, exp_q[i]); end
         n_cmp++; if (a_phase !== exp_p[i]) begin n_err++; $display("FAIL rev_phase[%0d] got %0d exp %0d", i, a_phase, exp_p[i]); end
         n_cmp++; if (a_wrap !== (i == 3)) begin n_err++; $display("FAIL rev_wrap[%0d] got %b exp %b", i, a_wrap, (i == 3)); end
      end
      // direction flips back: 0001 forward wraps to 0000
      a_dir = 1'b1;
      tick();
      n_cmp++; if (a_q !== 4'b0000 || a_wrap !== 1'b1) begin n_err++; $display("FAIL dir_flip got %b wrap %b exp 0000 wrap 1", a_q, a_wrap); end
   endtask

   task automatic test_load();
      a_en = 1'b1; a_dir = 1'b0; a_load = 1'b1; a_load_val = 4'b0111;
      tick();
      n_cmp++; if (a_q !== 4'b0111 || a_phase !== 3'd5) begin n_err++; $display("FAIL load_legal got %b/%0d exp 0111/5", a_q, a_phase); end
      n_cmp++; if (a_wrap !== 1'b0 || a_ill !== 1'b0) begin n_err++; $display("FAIL load_legal_pulses got %b%b exp 00", a_wrap, a_ill); end
      a_load_val = 4'b0101;
      tick();
      n_cmp++; if (a_q !== 4'b0000 || a_phase !== 3'd0) begin n_err++; $display("FAIL load_illegal got %b/%0d exp 0000/0", a_q, a_phase); end
      n_cmp++; if (a_ill !== 1'b1) begin n_err++; $display("FAIL load_illegal_flag got %b exp 1", a_ill); end
      a_load = 1'b0; a_en = 1'b0;
      tick();
      n_cmp++; if (a_ill !== 1'b0 || a_q !== 4'b0000) begin n_err++; $display("FAIL load_illegal_clear got %b/%b exp 0/0000", a_ill, a_q); end
   endtask

   task automatic test_ring();
      logic [3:0] exp_q [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
      logic [2:0] exp_p [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
      b_en = 1'b1; b_dir = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (b_q !== exp_q[i] || b_phase !== exp_p[i]) begin n_err++; $display("FAIL ring_fwd[%0d] got %b/%0d exp %b/%0d", i, b_q, b_phase, exp_q[i], exp_p[i]); end
         n_cmp++; if (b_wrap !== (i == 3)) begin n_err++; $display("FAIL ring_wrap[%0d] got %b exp %b", i, b_wrap, (i == 3)); end
      end
      b_dir = 1'b0;
      tick();
      n_cmp++; if (b_q !== 4'b0001 || b_phase !== 3'd3 || b_wrap !== 1'b1) begin n_err++; $display("FAIL ring_rev got %b/%0d/%b exp 0001/3/1", b_q, b_phase, b_wrap); end
      b_en = 1'b1; b_dir = 1'b1;
      force u_r4.q_q = 4'b1100;
      #1;
      release u_r4.q_q;
      tick();
      n_cmp++; if (b_q !== 4'b1000 || b_phase !== 3'd0) begin n_err++; $display("FAIL ring_seu got %b/%0d exp 1000/0", b_q, b_phase); end
      n_cmp++; if (b_ill !== 1'b1 || b_wrap !== 1'b0) begin n_err++; $display("FAIL ring_seu_pulses got ill %b wrap %b exp 1 0", b_ill, b_wrap); end
      b_en = 1'b0;
      tick();
      n_cmp++; if (b_ill !== 1'b0) begin n_err++; $display("FAIL ring_seu_clear got %b exp 0", b_ill); end
   endtask

   task automatic test_rst_mid();
      a_en = 1'b1; a_dir = 1'b1;
      repeat (4) tick();
      n_cmp++; if (a_q !== 4'b1111 || a_phase !== 3'd4) begin n_err++; $display("FAIL mid_start got %b/%0d exp 1111/4", a_q, a_phase); end
      a_rst = 1'b0; a_load = 1'b1; a_load_val = 4'b0011;
      tick();
      n_cmp++; if (a_q !== 4'b0000 || a_phase !== 3'd0 || a_wrap !== 1'b0) begin n_err++; $display("FAIL mid_rst got %b/%0d/%b exp 0000/0/0", a_q, a_phase, a_wrap); end
      a_rst = 1'b1; a_load = 1'b0;
      tick();
      a_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (a_q !== 4'b1000 || a_phase !== 3'd1) begin n_err++; $display("FAIL hold_q[%0d] got %b/%0d exp 1000/1", i, a_q, a_phase); end
         n_cmp++; if (a_wrap !== 1'b0 || a_ill !== 1'b0) begin n_err++; $display("FAIL hold_pulses[%0d] got %b%b exp 00", i, a_wrap, a_ill); end
      end
   endtask

   task automatic test_back_to_back();
      c_en = 1'b1; c_dir = 1'b1; c_load = 1'b1; c_load_val = 6'b111000;
      tick();
      n_cmp++; if (c_q !== 6'b111000 || c_phase !== 4'd3) begin n_err++; $display("FAIL w6_load_wins got %b/%0d exp 111000/3", c_q, c_phase); end
      c_load_val = 6'b000000;
      tick();
      n_cmp++; if (c_q !== 6'b000000 || c_wrap !== 1'b0) begin n_err++; $display("FAIL w6_reload got %b/%b exp 000000/0", c_q, c_wrap); end
      c_load = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         n_cmp++; if (c_phase !== 4'(i % 12)) begin n_err++; $display("FAIL w6_phase[%0d] got %0d exp %0d", i, c_phase, i % 12); end
         n_cmp++; if (c_wrap !== (i == 12)) begin n_err++; $display("FAIL w6_wrap[%0d] got %b exp %b", i, c_wrap, (i == 12)); end
         if (i == 6) begin
            n_cmp++; if (c_q !== 6'b111111) begin n_err++; $display("FAIL w6_mid got %b exp 111111", c_q); end
         end
         if (i == 9) begin
            n_cmp++; if (c_q !== 6'b000111) begin n_err++; $display("FAIL w6_nine got %b exp 000111", c_q); end
         end
      end
      n_cmp++; if (c_q !== 6'b000000) begin n_err++; $display("FAIL w6_end got %b exp 000000", c_q); end
   endtask

   initial begin
      test_reset();
      test_johnson_fwd();
      test_johnson_rev();
      test_load();
      test_ring();
      test_rst_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
